spike_rate_decoder: RTL and testbench

- Downstream consumer of the fixed-point LIF neuron's 1-bit spike output.
- Converts the spike train into rate-coded spike counts over fixed windows of WINDOW cycles.
- Buffers the counts in a small FIFO and presents them on a valid/ready stream to the readout/classifier stage.
- Reports windows lost to back-pressure.

---
 rtl/spike_decoder_pkg.sv | 22 ++
 rtl/spike_count_fifo.sv | 75 +++++++
 rtl/spike_rate_decoder.sv | 146 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_decoder_pkg.sv
// Shared types and sizing helpers for the spike-rate decoder and its result FIFO.
package spike_decoder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   localparam int unsigned COUNT_W_DEF = 8;

   typedef logic [COUNT_W_DEF-1:0] count_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy must represent 0..depth inclusive.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/spike_count_fifo.sv
// Synchronous result FIFO with a registered head, registered valid/full flags
// and acceptance of a push while full when a pop happens in the same cycle.
module spike_count_fifo
   import spike_decoder_pkg::*;
#(
   parameter int unsigned DATA_W = COUNT_W_DEF,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_i,
   input  logic [DATA_W-1:0]             push_data_i,
   input  logic                          pop_i,
   output logic                          full_o,
   output logic                          valid_o,
   output logic [level_width(DEPTH)-1:0] level_o,
   output logic [DATA_W-1:0]             head_o
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned LVL_W = level_width(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              full_q, valid_q;
   logic              do_pop_c, do_push_c;

   always_comb begin
      do_pop_c  = pop_i & valid_q;
      do_push_c = push_i & (~full_q | do_pop_c);
      wr_ptr_d  = do_push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = do_pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d   = level_q + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
      head_d    = '0;
      // A push into a FIFO that is (or is becoming) empty bypasses the array.
      if (do_push_c && (level_q == LVL_W'(do_pop_c))) begin
         head_d = push_data_i;
      end else if (level_d != '0) begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         full_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (do_push_c) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         full_q   <= (level_d == LVL_W'(DEPTH));
         valid_q  <= (level_d != '0);
      end
   end

   assign full_o  = full_q;
   assign valid_o = valid_q;
   assign level_o = level_q;
   assign head_o  = head_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-codes a 1-bit spike train into per-window counts buffered on a valid/ready stream.
// Optional SPIKE_RATE_DECODER_ISI_EN adds last_isi, the latest inter-spike interval.
module spike_rate_decoder
   import spike_decoder_pkg::*;
#(
   parameter int unsigned WINDOW     = 16,
   parameter int unsigned COUNT_W    = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DROP_W     = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               spike_in,
   input  logic                               enable,
   output logic [COUNT_W-1:0]                 out_count,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               overflow,
   output logic [DROP_W-1:0]                  drop_count,
   output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
`ifdef SPIKE_RATE_DECODER_ISI_EN
   ,output logic [15:0]                       last_isi
`endif
);

   localparam int unsigned PHASE_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned LVL_W   = level_width(FIFO_DEPTH);
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(WINDOW - 1);

   typedef logic [COUNT_W-1:0] win_count_t;

   state_e             state_q;
   logic [PHASE_W-1:0] phase_q;
   win_count_t         acc_q;
   win_count_t         sum_c;
   logic               push_c, pop_c, drop_c;
   logic               fifo_full, fifo_valid;
   logic [LVL_W-1:0]   fifo_lvl;
   win_count_t         fifo_head;
   logic               overflow_q;
   logic [DROP_W-1:0]  drop_q;

   always_comb begin
      sum_c  = (&acc_q) ? acc_q : acc_q + COUNT_W'(spike_in);
      push_c = enable & (state_q == COUNT) & (phase_q == LAST_PHASE);
      pop_c  = fifo_valid & out_ready;
      drop_c = push_c & fifo_full & ~pop_c;
   end

   // Window FSM: entering COUNT counts the entry cycle as sample 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         acc_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q <= COUNT;
                  acc_q   <= sum_c;
                  phase_q <= PHASE_W'(1);
               end
            end
            COUNT: begin
               if (!enable) begin
                  state_q <= IDLE;
                  acc_q   <= '0;
                  phase_q <= '0;
               end else if (phase_q == LAST_PHASE) begin
                  acc_q   <= '0;
                  phase_q <= '0;
               end else begin
                  acc_q   <= sum_c;
                  phase_q <= phase_q + PHASE_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (drop_c) begin
         overflow_q <= 1'b1;
         if (!(&drop_q)) begin
            drop_q <= drop_q + DROP_W'(1);
         end
      end
   end

   spike_count_fifo #(
      .DATA_W (COUNT_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_c),
      .push_data_i (sum_c),
      .pop_i       (pop_c),
      .full_o      (fifo_full),
      .valid_o     (fifo_valid),
      .level_o     (fifo_lvl),
      .head_o      (fifo_head)
   );

   assign out_count  = fifo_head;
   assign out_valid  = fifo_valid;
   assign fifo_level = fifo_lvl;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

`ifdef SPIKE_RATE_DECODER_ISI_EN
   logic [15:0] isi_gap_q;
   logic [15:0] isi_d;
   logic        isi_seen_q;
   logic [15:0] last_isi_q;

   assign isi_d = (&isi_gap_q) ? 16'hFFFF : isi_gap_q + 16'd1;

   // Gap counter spans window boundaries; only leaving COUNT (enable low) clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         isi_gap_q  <= '0;
         isi_seen_q <= 1'b0;
         last_isi_q <= '0;
      end else if (!enable) begin
         isi_gap_q  <= '0;
         isi_seen_q <= 1'b0;
      end else if (spike_in) begin
         if (isi_seen_q) begin
            last_isi_q <= isi_d;
         end
         isi_seen_q <= 1'b1;
         isi_gap_q  <= '0;
      end else if (isi_seen_q && !(&isi_gap_q)) begin
         isi_gap_q <= isi_gap_q + 16'd1;
      end
   end

   assign last_isi = last_isi_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench: two decoders (default and narrow count/drop widths) share stimulus
// and are compared every cycle against a queue-based window/FIFO model.
module tb_spike_rate_decoder;

   localparam int unsigned WIN   = 16;
   localparam int unsigned CW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned CW_S  = 3;
   localparam int unsigned DW_S  = 3;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic            clk;
   logic            rst;
   logic            spike_in;
   logic            enable;
   logic            out_ready;
   logic [CW-1:0]   out_count;
   logic            out_valid;
   logic            overflow;
   logic [DW-1:0]   drop_count;
   logic [LW-1:0]   fifo_level;
   logic [CW_S-1:0] s_out_count;
   logic            s_out_valid;
   logic            s_overflow;
   logic [DW_S-1:0] s_drop_count;
   logic [LW-1:0]   s_fifo_level;
`ifdef SPIKE_RATE_DECODER_ISI_EN
   logic [15:0]     last_isi;
   logic [15:0]     s_last_isi;
`endif

   spike_rate_decoder #(.WINDOW(WIN), .COUNT_W(CW), .FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
      .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable),
      .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
`ifdef SPIKE_RATE_DECODER_ISI_EN
      , .last_isi(last_isi)
`endif
   );

   spike_rate_decoder #(.WINDOW(WIN), .COUNT_W(CW_S), .FIFO_DEPTH(DEPTH), .DROP_W(DW_S)) dut_sat (
      .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable),
      .out_count(s_out_count), .out_valid(s_out_valid), .out_ready(out_ready),
      .overflow(s_overflow), .drop_count(s_drop_count), .fifo_level(s_fifo_level)
`ifdef SPIKE_RATE_DECODER_ISI_EN
      , .last_isi(s_last_isi)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state: raw window sums, unsaturated drop count, and spike timing.
   int q[$];
   int run_len, win_sum, drops, cyc, last_sp_cyc, m_isi;
   bit ovf, have_sp;

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic model_clear();
      q.delete();
      run_len = 0; win_sum = 0; drops = 0; ovf = 0;
      have_sp = 0; m_isi = 0; cyc = 0; last_sp_cyc = 0;
   endtask

   task automatic model_step(input bit en, input bit sp, input bit rdy);
      bit pop, push;
      int val;
      cyc++;
      pop  = (q.size() != 0) && rdy;
      push = 0;
      val  = 0;
      if (en) begin
         win_sum += int'(sp);
         run_len++;
         if (run_len == int'(WIN)) begin
            push = 1; val = win_sum; win_sum = 0; run_len = 0;
         end
         if (sp) begin
            if (have_sp) m_isi = sat(cyc - last_sp_cyc, 65535);
            have_sp = 1;
            last_sp_cyc = cyc;
         end
      end else begin
         win_sum = 0; run_len = 0; have_sp = 0;
      end
      if (push && !(q.size() < int'(DEPTH) || pop)) begin
         drops++;
         ovf = 1;
         push = 0;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(val);
   endtask

   task automatic check_all();
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("valid_s", 32'(s_out_valid), 32'(q.size() != 0));
      chk("level_s", 32'(s_fifo_level), 32'(q.size()));
      if (q.size() != 0) begin
         chk("count", 32'(out_count), 32'(sat(q[0], 255)));
         chk("count_s", 32'(s_out_count), 32'(sat(q[0], 7)));
      end
      chk("overflow", 32'(overflow), 32'(ovf));
      chk("overflow_s", 32'(s_overflow), 32'(ovf));
      chk("drops", 32'(drop_count), 32'(sat(drops, 255)));
      chk("drops_s", 32'(s_drop_count), 32'(sat(drops, 7)));
`ifdef SPIKE_RATE_DECODER_ISI_EN
      chk("isi", 32'(last_isi), 32'(m_isi));
      chk("isi_s", 32'(s_last_isi), 32'(m_isi));
`endif
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_count"}, 32'(out_count), 32'd0);
      chk({nm, "_ovf"}, 32'(overflow), 32'd0);
      chk({nm, "_drops"}, 32'(drop_count), 32'd0);
      chk({nm, "_level"}, 32'(fifo_level), 32'd0);
      chk({nm, "_level_s"}, 32'(s_fifo_level), 32'd0);
`ifdef SPIKE_RATE_DECODER_ISI_EN
      chk({nm, "_isi"}, 32'(last_isi), 32'd0);
`endif
   endtask

   task automatic rand_inputs();
      enable    = 1'($urandom_range(0, 1));
      spike_in  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
   endtask

   // Called at a falling edge; asserts reset mid-cycle to prove the clear is asynchronous.
   task automatic do_reset(input int n);
      #2;
      rst = 1'b1;
      rand_inputs();
      #1;
      check_zero("rst_async");
      model_clear();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rand_inputs();
         check_zero("rst_hold");
      end
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
      check_zero("rst_rel");
   endtask

   task automatic step(input bit en, input bit sp, input bit rdy);
      enable = en; spike_in = sp; out_ready = rdy;
      model_step(en, sp, rdy);
      @(negedge clk);
      check_all();
   endtask

   int bp_cnt[5];
   int bp_exp[4];
   int rdy_pct, sp_pct, en_pct;

   initial begin
      rst = 1'b0; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
      model_clear();
      @(negedge clk);
      do_reset(3);

      // Full-rate window then alternating spikes, back to back.
      for (int i = 0; i < 16; i++) step(1, 1, 1);
      chk("full_rate_valid", 32'(out_valid), 32'd1);
      chk("full_rate_count", 32'(out_count), 32'd16);
      chk("full_rate_sat", 32'(s_out_count), 32'd7);
      for (int i = 0; i < 16; i++) step(1, (i % 2) == 0, 1);
      chk("alt_count", 32'(out_count), 32'd8);
      chk("alt_sat", 32'(s_out_count), 32'd7);

      // Back-pressure: five windows into a four-deep FIFO.
      do_reset(1);
      bp_cnt = '{3, 5, 7, 9, 11};
      bp_exp = '{3, 5, 7, 9};
      for (int w = 0; w < 5; w++)
         for (int i = 0; i < 16; i++) step(1, i < bp_cnt[w], 0);
      chk("bp_level", 32'(fifo_level), 32'd4);
      chk("bp_ovf", 32'(overflow), 32'd1);
      chk("bp_drops", 32'(drop_count), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("bp_head", 32'(out_count), 32'(bp_exp[k]));
         step(0, 0, 1);
      end
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Full FIFO with a pop exactly on the push cycle.
      do_reset(1);
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < 16; i++) step(1, i <= w, 0);
      for (int i = 0; i < 15; i++) step(1, 1, 0);
      step(1, 1, 1);
      chk("fullpop_level", 32'(fifo_level), 32'd4);
      chk("fullpop_drops", 32'(drop_count), 32'd0);
      chk("fullpop_ovf", 32'(overflow), 32'd0);
      chk("fullpop_head", 32'(out_count), 32'd2);

      // Enable abort at phase 10 discards the partial window.
      do_reset(1);
      for (int i = 0; i < 10; i++) step(1, i < 7, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1);
      chk("abort_nopush", 32'(out_valid), 32'd0);
      for (int i = 0; i < 16; i++) step(1, i < 2, 1);
      chk("abort_valid", 32'(out_valid), 32'd1);
      chk("abort_count", 32'(out_count), 32'd2);

`ifdef SPIKE_RATE_DECODER_ISI_EN
      do_reset(1);
      step(1, 1, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 1);
      step(1, 1, 1);
      chk("isi_5", 32'(last_isi), 32'd5);
`endif

      // Randomised traffic with varying spike density, enable and back-pressure.
      do_reset(1);
      for (int i = 0; i < 4000; i++) begin
         if (i % 150 == 0) begin
            rdy_pct = $urandom_range(0, 100);
            sp_pct  = $urandom_range(0, 100);
            en_pct  = $urandom_range(90, 100);
         end
         if (i == 2000) do_reset(2);
         step($urandom_range(0, 99) < en_pct, $urandom_range(0, 99) < sp_pct,
              $urandom_range(0, 99) < rdy_pct);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
